// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bundles the MEM-stage inputs and the WB-stage outputs of mem_wb_stage.
//   master : MEM-side driver (drives stall/flush and mem_*, observes WB outputs)
//   slave  : the MEM/WB register itself
//   Signals:
//     stall, flush                     pipeline control
//     mem_valid, mem_RegWrite          MEM instruction qualifiers
//     mem_writeReg                     destination GPR
//     mem_aluResult                    ALU result / load byte address
//     mem_memData                      aligned word read from data memory
//     mem_pcPlus8                      link value
//     mem_wbSel, mem_loadType          write-back source and load flavour
//     wb_valid, RegWrite, writeReg,
//     writeData                        register-file write port / WB bypass source
//     align_err                        misaligned-load pulse
//     retired_cnt                      retired-instruction counter
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic              mem_RegWrite;
    logic [REG_AW-1:0] mem_writeReg;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_memData;
    logic [DATA_W-1:0] mem_pcPlus8;
    logic [1:0]        mem_wbSel;
    logic [2:0]        mem_loadType;

    logic              wb_valid;
    logic              RegWrite;
    logic [REG_AW-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              align_err;
    logic [31:0]       retired_cnt;

    modport master (
        output stall, flush, mem_valid, mem_RegWrite, mem_writeReg,
               mem_aluResult, mem_memData, mem_pcPlus8, mem_wbSel, mem_loadType,
        input  wb_valid, RegWrite, writeReg, writeData, align_err, retired_cnt
    );

    modport slave (
        input  stall, flush, mem_valid, mem_RegWrite, mem_writeReg,
               mem_aluResult, mem_memData, mem_pcPlus8, mem_wbSel, mem_loadType,
        output wb_valid, RegWrite, writeReg, writeData, align_err, retired_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and write-back selector. Extracts and extends
//   load bytes/halfwords, picks ALU / load / link data and drives the register
//   file write port. The registered outputs double as the WB bypass source.
//   Ports:
//     clk    pipeline clock
//     reset  asynchronous active-low reset, clears all state
//     bus    mem_wb_stage_if.slave (MEM inputs in, WB outputs out)
//   Build option:
//     MEM_WB_PERF_CNT_EN  when defined, retired_cnt counts loaded valid
//                         instructions; otherwise it is tied to zero.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    mem_wb_stage_if.slave bus
);
    localparam logic [2:0] LT_LB   = 3'd1;
    localparam logic [2:0] LT_LBU  = 3'd2;
    localparam logic [2:0] LT_LH   = 3'd3;
    localparam logic [2:0] LT_LHU  = 3'd4;
    localparam logic [1:0] SEL_LD  = 2'd1;
    localparam logic [1:0] SEL_LNK = 2'd2;

    logic [1:0]        byte_addr;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] sel_val;
    logic              is_half;
    logic              is_word;
    logic              misalign;

    logic              wb_valid_q;
    logic              reg_write_q;
    logic [REG_AW-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              align_err_q;

    assign byte_addr = bus.mem_aluResult[1:0];

    always_comb begin
        ld_byte = bus.mem_memData[{byte_addr, 3'b000} +: 8];
        ld_half = byte_addr[1] ? bus.mem_memData[31:16] : bus.mem_memData[15:0];
        is_half = (bus.mem_loadType == LT_LH) || (bus.mem_loadType == LT_LHU);
        // Codes 5-7 fall through to the word path, including its alignment rule.
        is_word = !is_half && (bus.mem_loadType != LT_LB) && (bus.mem_loadType != LT_LBU);

        case (bus.mem_loadType)
            LT_LB:   load_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LT_LBU:  load_val = {{(DATA_W-8){1'b0}}, ld_byte};
            LT_LH:   load_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LT_LHU:  load_val = {{(DATA_W-16){1'b0}}, ld_half};
            default: load_val = bus.mem_memData;
        endcase

        case (bus.mem_wbSel)
            SEL_LD:  sel_val = load_val;
            SEL_LNK: sel_val = bus.mem_pcPlus8;
            default: sel_val = bus.mem_aluResult;
        endcase

        misalign = bus.mem_valid && (bus.mem_wbSel == SEL_LD) &&
                   ((is_half && byte_addr[0]) || (is_word && (byte_addr != 2'd0)));
    end

    // flush > stall > load. A stall holds everything but align_err so the
    // error stays a single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            align_err_q  <= 1'b0;
        end else if (bus.flush) begin
            wb_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            align_err_q <= 1'b0;
        end else if (bus.stall) begin
            align_err_q <= 1'b0;
        end else begin
            wb_valid_q   <= bus.mem_valid;
            // $0 writes are killed here so the bypass never forwards them.
            reg_write_q  <= bus.mem_valid && bus.mem_RegWrite &&
                            (bus.mem_writeReg != '0) && !misalign;
            write_reg_q  <= bus.mem_writeReg;
            write_data_q <= sel_val;
            align_err_q  <= misalign;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.RegWrite  = reg_write_q;
    assign bus.writeReg  = write_reg_q;
    assign bus.writeData = write_data_q;
    assign bus.align_err = align_err_q;

`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0] retired_q;

    // Misaligned loads still retire (as faulting instructions), so they count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (!bus.flush && !bus.stall && bus.mem_valid) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.retired_cnt = retired_q;
`else
    assign bus.retired_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
module tb_mem_wb_stage;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model of the WB outputs.
    logic        m_valid, m_rw, m_err;
    logic [4:0]  m_reg;
    logic [31:0] m_data, m_cnt;

    logic [31:0] ld_addr [6] = '{32'h1003, 32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1000};
    logic [2:0]  ld_type [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
    logic [31:0] ld_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] lt);
        int unsigned a = addr % 4;
        logic [31:0] b = (word >> (8 * a)) & 32'hFF;
        logic [31:0] h = (word >> (16 * (a / 2))) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return word;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [2:0] lt);
        int unsigned a = addr % 4;
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return (a % 2) != 0;
        return a != 0;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_err = 0; m_reg = 0; m_data = 0; m_cnt = 0;
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] md, input logic [31:0] pc8, input logic [1:0] sel,
                         input logic [2:0] lt);
        bus.mem_valid     = v;
        bus.mem_RegWrite  = rw;
        bus.mem_writeReg  = rd;
        bus.mem_aluResult = alu;
        bus.mem_memData   = md;
        bus.mem_pcPlus8   = pc8;
        bus.mem_wbSel     = sel;
        bus.mem_loadType  = lt;
    endtask

    // One clock: model applies the rules at the posedge, outputs are checked
    // by the caller at the following negedge.
    task automatic step();
        bit mis;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else if (bus.flush) begin
            m_valid = 0; m_rw = 0; m_err = 0;
        end else if (bus.stall) begin
            m_err = 0;
        end else begin
            mis = bus.mem_valid && (bus.mem_wbSel == 2'd1) &&
                  ref_misaligned(bus.mem_aluResult, bus.mem_loadType);
            m_valid = bus.mem_valid;
            m_rw    = bus.mem_valid && bus.mem_RegWrite && (bus.mem_writeReg != 0) && !mis;
            m_reg   = bus.mem_writeReg;
            if (bus.mem_wbSel == 2'd1)      m_data = ref_load(bus.mem_memData, bus.mem_aluResult, bus.mem_loadType);
            else if (bus.mem_wbSel == 2'd2) m_data = bus.mem_pcPlus8;
            else                            m_data = bus.mem_aluResult;
            m_err   = mis;
`ifdef MEM_WB_PERF_CNT_EN
            if (bus.mem_valid) m_cnt = m_cnt + 1;
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0;
        bus.stall = 0;
        bus.flush = 0;
        model_clear();
        drive(1, 1, 5'd5, 32'hCAFE_0005, 32'h0, 32'h0, 2'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b exp 0", bus.wb_valid); end
            checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %b exp 0", bus.RegWrite); end
            checks++; if (bus.writeReg !== 5'd0) begin errors++; $display("FAIL rst_writereg got %0d exp 0", bus.writeReg); end
            checks++; if (bus.writeData !== 32'h0) begin errors++; $display("FAIL rst_writedata got %h exp 0", bus.writeData); end
            checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL rst_align_err got %b exp 0", bus.align_err); end
            checks++; if (bus.retired_cnt !== 32'h0) begin errors++; $display("FAIL rst_retired got %h exp 0", bus.retired_cnt); end
        end
        reset = 1;
        step();
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rst_rel_valid got %b exp 1", bus.wb_valid); end
        checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL rst_rel_regwrite got %b exp 1", bus.RegWrite); end
        checks++; if (bus.writeReg !== 5'd5) begin errors++; $display("FAIL rst_rel_writereg got %0d exp 5", bus.writeReg); end
        checks++; if (bus.writeData !== 32'hCAFE_0005) begin errors++; $display("FAIL rst_rel_writedata got %h exp cafe0005", bus.writeData); end
    endtask

    task automatic test_alu_write();
        drive(1, 1, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 2'd0, 3'd0);
        step();
        checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %b exp 1", bus.RegWrite); end
        checks++; if (bus.writeReg !== 5'd8) begin errors++; $display("FAIL alu_writereg got %0d exp 8", bus.writeReg); end
        checks++; if (bus.writeData !== 32'h1234_5678) begin errors++; $display("FAIL alu_writedata got %h exp 12345678", bus.writeData); end
        drive(1, 1, 5'd0, 32'h1234_5678, 32'h0, 32'h0, 2'd3, 3'd0);
        step();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL alu_r0_regwrite got %b exp 0", bus.RegWrite); end
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL alu_r0_valid got %b exp 1", bus.wb_valid); end
        checks++; if (bus.writeData !== 32'h1234_5678) begin errors++; $display("FAIL alu_sel3_writedata got %h exp 12345678", bus.writeData); end
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 5'd3, ld_addr[i], 32'h80FF_7F01, 32'h0, 2'd1, ld_type[i]);
            step();
            checks++; if (bus.writeData !== ld_exp[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, bus.writeData, ld_exp[i]); end
            checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL load%0d_regwrite got %b exp 1", i, bus.RegWrite); end
            checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL load%0d_align got %b exp 0", i, bus.align_err); end
        end
    endtask

    task automatic test_misalign();
        drive(1, 1, 5'd9, 32'h2001, 32'h80FF_7F01, 32'h0, 2'd1, 3'd3);
        step();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mis_lh_regwrite got %b exp 0", bus.RegWrite); end
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL mis_lh_align got %b exp 1", bus.align_err); end
        drive(1, 1, 5'd9, 32'h2002, 32'h80FF_7F01, 32'h0, 2'd1, 3'd0);
        step();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mis_lw_regwrite got %b exp 0", bus.RegWrite); end
        checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL mis_lw_align got %b exp 1", bus.align_err); end
        bus.stall = 1;
        step();
        bus.stall = 0;
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL mis_stall_align got %b exp 0", bus.align_err); end
        drive(1, 1, 5'd9, 32'h2000, 32'h80FF_7F01, 32'h0, 2'd1, 3'd0);
        step();
        checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL mis_ok_align got %b exp 0", bus.align_err); end
        checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL mis_ok_regwrite got %b exp 1", bus.RegWrite); end
        checks++; if (bus.writeData !== 32'h80FF_7F01) begin errors++; $display("FAIL mis_ok_data got %h exp 80ff7f01", bus.writeData); end
    endtask

    task automatic test_stall_flush();
        drive(1, 1, 5'd31, 32'h0000_0BAD, 32'hDEAD_BEEF, 32'h0040_0008, 2'd2, 3'd0);
        step();
        checks++; if (bus.writeData !== 32'h0040_0008) begin errors++; $display("FAIL link_data got %h exp 00400008", bus.writeData); end
        drive(1, 1, 5'd4, 32'h5555_AAAA, 32'h0, 32'h0, 2'd0, 3'd0);
        bus.stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.writeReg !== 5'd31) begin errors++; $display("FAIL stall%0d_writereg got %0d exp 31", i, bus.writeReg); end
            checks++; if (bus.writeData !== 32'h0040_0008) begin errors++; $display("FAIL stall%0d_data got %h exp 00400008", i, bus.writeData); end
            checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL stall%0d_regwrite got %b exp 1", i, bus.RegWrite); end
        end
        bus.flush = 1;
        step();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL flush_regwrite got %b exp 0", bus.RegWrite); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.wb_valid); end
        checks++; if (bus.writeData !== 32'h0040_0008) begin errors++; $display("FAIL flush_data got %h exp 00400008", bus.writeData); end
        bus.stall = 0;
        bus.flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom, $urandom, 2'($urandom), 3'($urandom));
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            step();
            checks++; if (bus.wb_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid got %b exp %b", i, bus.wb_valid, m_valid); end
            checks++; if (bus.RegWrite !== m_rw) begin errors++; $display("FAIL rnd%0d_regwrite got %b exp %b", i, bus.RegWrite, m_rw); end
            checks++; if (bus.writeReg !== m_reg) begin errors++; $display("FAIL rnd%0d_writereg got %0d exp %0d", i, bus.writeReg, m_reg); end
            checks++; if (bus.writeData !== m_data) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", i, bus.writeData, m_data); end
            checks++; if (bus.align_err !== m_err) begin errors++; $display("FAIL rnd%0d_align got %b exp %b", i, bus.align_err, m_err); end
            checks++; if (bus.retired_cnt !== m_cnt) begin errors++; $display("FAIL rnd%0d_retired got %h exp %h", i, bus.retired_cnt, m_cnt); end
        end
        bus.stall = 0;
        bus.flush = 0;
    endtask

    task automatic test_counter();
        logic [31:0] exp_cnt;
`ifdef MEM_WB_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        reset = 0;
        model_clear();
        #1;
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL cnt_async_regwrite got %b exp 0", bus.RegWrite); end
        checks++; if (bus.retired_cnt !== 32'h0) begin errors++; $display("FAIL cnt_async_retired got %h exp 0", bus.retired_cnt); end
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 5'(i + 1), 32'(i), 32'h0, 32'h0, 2'd0, 3'd0);
            step();
        end
        drive(0, 1, 5'd7, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0);
        step();
        drive(1, 1, 5'd7, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0);
        bus.stall = 1;
        step();
        step();
        bus.stall = 0;
        bus.flush = 1;
        step();
        bus.flush = 0;
        drive(0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0);
        checks++; if (bus.retired_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_total got %0d exp %0d", bus.retired_cnt, exp_cnt); end
        checks++; if (bus.retired_cnt !== m_cnt) begin errors++; $display("FAIL cnt_model got %0d exp %0d", bus.retired_cnt, m_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_misalign();
        test_stall_flush();
        test_random();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
